orao_tap_player: RTL and testbench

//  Streams a TAP image from hps_io's ioctl download into a byte FIFO. It replays
//  the bytes as a square-wave cassette signal for orao_hw's tape input and the

---
 rtl/orao_tap_player.sv | 156 +++++++++++++++
 tb/tb_orao_tap_player.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orao_tap_player.sv
// TAP cassette player: buffers hps_io download bytes in a small FIFO and replays
// them LSB first as a square-wave tape signal timed by the 1 MHz enable.
module orao_tap_player #(
  parameter int FIFO_AW     = 4,
  parameter int HALF0       = 416,
  parameter int HALF1       = 208,
  parameter int LEADER_BITS = 256
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic       tape_out,
  output logic       busy,
  output logic       overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int LW    = $clog2(LEADER_BITS + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEADER, S_LOAD, S_HI, S_LO} state_t;

  state_t             state_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               sel_q, overflow_q, tape_q;
  logic [9:0]         tick_q;
  logic [LW-1:0]      lead_q;
  logic [7:0]         sh_q;
  logic [2:0]         bitcnt_q;

  logic       sel, start, push, pop, shift, full, empty;
  logic [7:0] head;

  function automatic logic [9:0] half_ticks(input logic b);
    return b ? 10'(HALF1 - 1) : 10'(HALF0 - 1);
  endfunction

  assign sel   = ioctl_download & (ioctl_index == 8'h01);
  assign start = sel & ~sel_q;
  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  // A restart flush takes priority over any push or pop in the same cycle.
  assign push  = ioctl_wr & sel & ~full & ~start;
  assign pop   = ce_1m & (state_q == S_LOAD) & ~empty & ~start;
  assign shift = ce_1m & ~start & (state_q == S_LO) & (tick_q == '0) & (bitcnt_q != 3'd7);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= ioctl_dout;
    if (pop)        sh_q <= head;
    else if (shift) sh_q <= sh_q >> 1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tape_q     <= 1'b0;
      tick_q     <= '0;
      lead_q     <= '0;
      bitcnt_q   <= '0;
    end else begin
      sel_q <= sel;
      if (start) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        state_q    <= S_LEADER;
        tape_q     <= 1'b0;
        tick_q     <= '0;
        lead_q     <= LW'(LEADER_BITS);
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        if (ioctl_wr && sel && full) overflow_q <= 1'b1;
        if (ce_1m) begin
          // The last low half leaves one tick early so the LOAD step
          // lands on the next cell's rising edge with no gap.
          case (state_q)
            S_LEADER: begin
              if (!tape_q && lead_q == '0 && tick_q == 10'd1) state_q <= S_LOAD;
              else if (tick_q != '0) tick_q <= tick_q - 10'd1;
              else if (tape_q) begin
                tape_q <= 1'b0;
                tick_q <= half_ticks(1'b1);
              end else begin
                tape_q <= 1'b1;
                tick_q <= half_ticks(1'b1);
                lead_q <= lead_q - LW'(1);
              end
            end
            S_LOAD: begin
              if (!empty) begin
                state_q  <= S_HI;
                tape_q   <= 1'b1;
                tick_q   <= half_ticks(head[0]);
                bitcnt_q <= '0;
              end else if (!ioctl_download) begin
                state_q <= S_IDLE;
              end else begin
                tape_q <= 1'b0;
              end
            end
            S_HI: begin
              if (tick_q != '0) tick_q <= tick_q - 10'd1;
              else begin
                state_q <= S_LO;
                tape_q  <= 1'b0;
                tick_q  <= half_ticks(sh_q[0]);
              end
            end
            S_LO: begin
              if (bitcnt_q == 3'd7 && tick_q == 10'd1) state_q <= S_LOAD;
              else if (tick_q != '0) tick_q <= tick_q - 10'd1;
              else begin
                state_q  <= S_HI;
                tape_q   <= 1'b1;
                tick_q   <= half_ticks(sh_q[1]);
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
            default: begin
              state_q <= S_IDLE;
              tape_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign ioctl_wait = (count_q >= WAIT_LVL) | ((state_q == S_IDLE) & sel);
  assign tape_out   = tape_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_orao_tap_player.sv
// Directed bench for orao_tap_player with shortened bit timing; a monitor
// decodes tape_out cells back into bits and bytes.
module tb_orao_tap_player;
  localparam int FIFO_AW = 4;
  localparam int HALF0   = 6;
  localparam int HALF1   = 3;
  localparam int LB      = 4;
  localparam int CEP     = 3;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_1m = 1'b0;
  logic       ioctl_download = 1'b0;
  logic [7:0] ioctl_index = 8'h00;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_dout = 8'h00;
  logic       ioctl_wait, tape_out, busy, overflow;

  int checks = 0;
  int failures = 0;

  int   cyc = 0;
  logic prev_tape = 1'b0;
  int   t_rise = 0, t_fall = 0;
  logic have_rise = 1'b0, have_fall = 1'b0;
  logic mon_clr = 1'b0;
  int   hi_q[$];
  int   lo_q[$];
  int   bit_q[$];

  orao_tap_player #(
    .FIFO_AW(FIFO_AW), .HALF0(HALF0), .HALF1(HALF1), .LEADER_BITS(LB)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_1m(ce_1m),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .tape_out(tape_out), .busy(busy), .overflow(overflow)
  );

  always #10 clk_sys = ~clk_sys;

  initial begin : ce_gen
    int k;
    k = 0;
    forever begin
      @(negedge clk_sys);
      ce_1m = (k == CEP - 1);
      k = (k + 1) % CEP;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk_sys);
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Cell monitor: high/low durations in clk_sys cycles, bit decoded from the high half.
  always @(negedge clk_sys) begin
    cyc <= cyc + 1;
    prev_tape <= tape_out;
    if (mon_clr) begin
      hi_q.delete();
      lo_q.delete();
      bit_q.delete();
      have_rise <= 1'b0;
      have_fall <= 1'b0;
    end else if (tape_out && !prev_tape) begin
      if (have_fall) lo_q.push_back(cyc - t_fall);
      t_rise <= cyc;
      have_rise <= 1'b1;
    end else if (!tape_out && prev_tape && have_rise) begin
      hi_q.push_back(cyc - t_rise);
      bit_q.push_back(((cyc - t_rise) == CEP*HALF1) ? 1 :
                      (((cyc - t_rise) == CEP*HALF0) ? 0 : 2));
      t_fall <= cyc;
      have_fall <= 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    @(posedge clk_sys);
    mon_clr = 1'b1;
    @(negedge clk_sys);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin @(negedge clk_sys); n++; end
    #1 chk(tag, int'(busy), 0);
  endtask

  task automatic wait_cnt(input string tag, input int val, input int maxc);
    int n;
    n = 0;
    while (int'(dut.count_q) != val && n < maxc) begin @(negedge clk_sys); n++; end
    chk(tag, int'(dut.count_q), val);
  endtask

  task automatic wait_tape(input string tag, input int lvl, input int maxc);
    int n;
    n = 0;
    while (int'(tape_out) != lvl && n < maxc) begin @(negedge clk_sys); n++; end
    chk(tag, int'(tape_out), lvl);
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] exp[$]);
    int ones;
    int idx;
    logic [7:0] v;
    ones = 0;
    chk({tag, "_nbits"}, bit_q.size(), LB + 8*exp.size());
    for (int i = 0; i < LB && i < bit_q.size(); i++) if (bit_q[i] == 1) ones++;
    chk({tag, "_leader"}, ones, LB);
    for (int b = 0; b < exp.size(); b++) begin
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
        idx = LB + 8*b + i;
        if (idx < bit_q.size()) v[i] = (bit_q[idx] == 1);
      end
      chk($sformatf("%s_byte%0d", tag, b), int'(v), int'(exp[b]));
    end
  endtask

  initial begin : stim
    logic [7:0] q[$];
    int sb_half[8];
    int n, fw, budget, ecell;
    sb_half = '{HALF1, HALF0, HALF1, HALF0, HALF0, HALF1, HALF0, HALF1};

    // Reset state
    repeat (3) @(negedge clk_sys);
    #1;
    chk("rst_tape", int'(tape_out), 0);
    chk("rst_wait", int'(ioctl_wait), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_count", int'(dut.count_q), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // Wrong index: nothing accepted, no back-pressure
    ioctl_index = 8'h00;
    ioctl_download = 1'b1;
    #1 chk("idx0_wait", int'(ioctl_wait), 0);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_dout = 8'h77;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    #1;
    chk("idx0_count", int'(dut.count_q), 0);
    chk("idx0_busy", int'(busy), 0);

    // Single byte A5
    mon_clear();
    @(negedge clk_sys);
    ioctl_index = 8'h01;
    #1 chk("sb_start_wait", int'(ioctl_wait), 1);
    @(negedge clk_sys);
    #1 chk("sb_start_busy", int'(busy), 1);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_dout = 8'hA5;
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    #1 chk("sb_count", int'(dut.count_q), 1);
    wait_idle("sb_idle", 3000);
    chk("sb_tape_end", int'(tape_out), 0);
    q = '{8'hA5};
    chk_stream("sb", q);
    chk("sb_nlo", lo_q.size(), LB + 7);
    for (int i = 0; i < LB + 8 && i < hi_q.size(); i++) begin
      ecell = (i < LB) ? CEP*HALF1 : CEP*sb_half[i-LB];
      chk($sformatf("sb_hi%0d", i), hi_q[i], ecell);
      if (i < lo_q.size()) chk($sformatf("sb_lo%0d", i), lo_q[i], ecell);
    end

    // Back-pressure: 40 writes, holding off while wait is high
    q.delete();
    mon_clear();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    n = 0; fw = -1; budget = 20000;
    while (n < 40 && budget > 0) begin
      @(negedge clk_sys);
      #1;
      if (ioctl_wait) begin
        ioctl_wr = 1'b0;
        if (fw < 0) fw = int'(dut.count_q);
      end else begin
        ioctl_wr = 1'b1;
        ioctl_dout = 8'(n*37 + 5);
        q.push_back(8'(n*37 + 5));
        n++;
      end
      budget--;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    chk("bp_written", n, 40);
    chk("bp_wait_level", fw, 15);
    wait_idle("bp_idle", 30000);
    chk("bp_ovf", int'(overflow), 0);
    chk_stream("bp", q);

    // Overflow: 17th write into a full FIFO is dropped
    q.delete();
    mon_clear();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 16; i++) begin
      ioctl_wr = 1'b1; ioctl_dout = 8'(8'hC0 + i);
      q.push_back(8'(8'hC0 + i));
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    #1;
    chk("ovf_full_count", int'(dut.count_q), 16);
    chk("ovf_pre", int'(overflow), 0);
    chk("ovf_full_wait", int'(ioctl_wait), 1);
    ioctl_wr = 1'b1; ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    #1;
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(dut.count_q), 16);
    ioctl_download = 1'b0;
    wait_idle("ovf_idle", 8000);
    chk("ovf_sticky", int'(overflow), 1);
    chk_stream("ovf", q);

    // Underrun: stall in LOAD with tape low, then resume
    q.delete();
    mon_clear();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_dout = 8'h3C;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    budget = 3000;
    while (bit_q.size() < LB + 8 && budget > 0) begin @(negedge clk_sys); budget--; end
    repeat (60) @(negedge clk_sys);
    #1;
    chk("ur_tape", int'(tape_out), 0);
    chk("ur_busy", int'(busy), 1);
    chk("ur_hold_bits", bit_q.size(), LB + 8);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_dout = 8'hC3;
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_idle("ur_idle", 3000);
    q = '{8'h3C, 8'hC3};
    chk_stream("ur", q);

    // Reset mid-LO with five bytes buffered and overflow set
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 17; i++) begin
      ioctl_wr = 1'b1; ioctl_dout = 8'(i);
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_cnt("mr_reach5", 5, 6000);
    wait_tape("mr_reach_lo", 0, 200);
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_tape", int'(tape_out), 0);
    chk("mr_wait", int'(ioctl_wait), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_ovf", int'(overflow), 0);
    chk("mr_count", int'(dut.count_q), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    #1;
    chk("mr_stay_idle", int'(busy), 0);
    chk("mr_stay_tape", int'(tape_out), 0);

    // Restart mid-playback flushes and re-enters LEADER
    mon_clear();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_dout = 8'(8'h11 * (i + 1));
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    wait_cnt("rs_reach2", 2, 1000);
    mon_clear();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    #1;
    chk("rs_flush", int'(dut.count_q), 0);
    chk("rs_busy", int'(busy), 1);
    chk("rs_tape", int'(tape_out), 0);
    ioctl_wr = 1'b1; ioctl_dout = 8'h5A;
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_idle("rs_idle", 3000);
    chk("rs_ovf", int'(overflow), 0);
    q = '{8'h5A};
    chk_stream("rs", q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
